pkt_out_arbiter: RTL and testbench

Round-robin arbiter that shares one switch output byte stream among `NUM_REQ` ingress queues. It sits between the per-port packet buffers and the packet output interface. It grants one requester at a time and emits a length header byte followed by the payload. Downstream backpressure is honoured through `package_ack`.

---
 rtl/pkt_out_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pkt_out_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_out_arbiter.sv
// rtl/pkt_out_arbiter.sv - round-robin packet output arbiter; optional per-requester packet counters under PKT_OUT_ARB_STATS_EN
module pkt_out_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_len,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_rd,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             package_out,
    output logic                   read_data_valid,
    output logic                   package_out_start,
    input  logic                   package_ack
`ifdef PKT_OUT_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]  pkt_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [7:0]         remain_q, remain_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [7:0]         len_arr  [NUM_REQ];
    logic [7:0]         data_arr [NUM_REQ];

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   scan_idx;
    int                 scan;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign len_arr[g]  = req_len[8*g +: 8];
        assign data_arr[g] = req_data[8*g +: 8];
    end

    // Cyclic search starting at ptr; the previous winner sits at the far end.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = 0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(ptr_q) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            scan_idx = IDX_W'(scan);
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        remain_d = remain_q;
        grant_d  = grant_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    sel_d             = pick_idx;
                    remain_d          = len_arr[pick_idx];
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = S_HDR;
                end
            end
            S_HDR: begin
                if (package_ack) begin
                    if (remain_q != 8'd0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_GAP;
                        grant_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (package_ack) begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = S_GAP;
                        grant_d = '0;
                    end
                end
            end
            S_GAP: begin
                ptr_d   = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            sel_q    <= '0;
            remain_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            remain_q <= remain_d;
            grant_q  <= grant_d;
        end
    end

    // remain still holds the full length while in HDR, so it doubles as the header byte.
    always_comb begin
        package_out = '0;
        case (state_q)
            S_HDR:   package_out = remain_q;
            S_DATA:  package_out = data_arr[sel_q];
            default: package_out = '0;
        endcase
    end

    assign grant             = grant_q;
    assign read_data_valid   = (state_q == S_HDR) || (state_q == S_DATA);
    assign package_out_start = (state_q == S_HDR);
    assign req_rd            = ((state_q == S_DATA) && package_ack) ? grant_q : '0;

`ifdef PKT_OUT_ARB_STATS_EN
    logic        gap_enter;
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    assign gap_enter = (state_d == S_GAP) && (state_q != S_GAP);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gap_enter && (sel_q == IDX_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign pkt_count[16*g +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_pkt_out_arbiter.sv
// tb/tb_pkt_out_arbiter.sv - self-checking bench for pkt_out_arbiter, directed cases plus randomized traffic against a packet-level model
module tb_pkt_out_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_len;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_rd;
    logic [N-1:0]     grant;
    logic [7:0]       package_out;
    logic             read_data_valid;
    logic             package_out_start;
    logic             package_ack;
`ifdef PKT_OUT_ARB_STATS_EN
    logic [16*N-1:0]  pkt_count;
`endif

    pkt_out_arbiter #(.NUM_REQ(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_len           (req_len),
        .req_data          (req_data),
        .req_rd            (req_rd),
        .grant             (grant),
        .package_out       (package_out),
        .read_data_valid   (read_data_valid),
        .package_out_start (package_out_start),
        .package_ack       (package_ack)
`ifdef PKT_OUT_ARB_STATS_EN
        ,
        .pkt_count         (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Requester side: FWFT byte queues plus a queue of packet lengths per port.
    byte unsigned env_data [N][$];
    int           env_len  [N][$];
    int           env_popped [N];
    logic [N-1:0] rd_s = '0;
    logic [N-1:0] gr_last = '0;

    // Reference model: what each port still owes the output, and the fairness pointer.
    byte unsigned exp_data [N][$];
    int           exp_len  [N][$];
    int           model_ptr = 0;

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req[i]           = (env_len[i].size() > 0);
            req_len[8*i +: 8]  = (env_len[i].size() > 0) ? 8'(env_len[i][0]) : 8'h00;
            req_data[8*i +: 8] = (env_data[i].size() > 0) ? env_data[i][0] : 8'h00;
        end
    endtask

    task automatic push(input int i, input int len, input byte unsigned base);
        byte unsigned b;
        env_len[i].push_back(len);
        exp_len[i].push_back(len);
        for (int k = 0; k < len; k++) begin
            b = byte'(base + k * 3);
            env_data[i].push_back(b);
            exp_data[i].push_back(b);
        end
        drive_req();
    endtask

    always @(negedge clk) begin
        #3;
        rd_s = req_rd;
    end

    always @(posedge clk) begin
        int n;
        logic [N-1:0] gr_now;
        #1;
        gr_now = grant;
        for (int i = 0; i < N; i++) begin
            if (rd_s[i] && env_data[i].size() > 0) begin
                void'(env_data[i].pop_front());
                env_popped[i]++;
            end
            if (gr_last[i] && !gr_now[i] && env_len[i].size() > 0) begin
                n = env_len[i].pop_front();
                for (int k = env_popped[i]; k < n; k++) begin
                    if (env_data[i].size() > 0) void'(env_data[i].pop_front());
                end
                env_popped[i] = 0;
            end
        end
        gr_last = gr_now;
        drive_req();
    end

    // Packet-level monitor.
    bit mon_en = 1'b0;
    bit in_hdr, active, had_pkt;
    int cur, cur_len, idle_run, pkts_done;

    function automatic int model_pick();
        int j;
        for (int k = 0; k < N; k++) begin
            j = (model_ptr + k) % N;
            if (exp_len[j].size() > 0) return j;
        end
        return -1;
    endfunction

    task automatic finish_pkt();
        active    = 1'b0;
        had_pkt   = 1'b1;
        idle_run  = 0;
        pkts_done++;
    endtask

    always @(negedge clk) begin
        int s;
        if (mon_en) begin
            #2;
            if (read_data_valid && package_out_start) begin
                if (!in_hdr) begin
                    s = model_pick();
                    if (s < 0) begin
                        chk("spurious_hdr", 32'd1, 32'd0);
                    end else begin
                        chk("rr_grant", grant, oh(s));
                        chk("hdr_len", package_out, exp_len[s][0]);
                        if (had_pkt) chk("hdr_gap", idle_run, 32'd2);
                        cur       = s;
                        cur_len   = exp_len[s].pop_front();
                        model_ptr = (s + 1) % N;
                        active    = 1'b1;
                        in_hdr    = 1'b1;
                    end
                end else begin
                    chk("hdr_hold", package_out, cur_len);
                end
                chk("hdr_rd", req_rd, 32'd0);
                idle_run = 0;
                if (package_ack && active) begin
                    in_hdr = 1'b0;
                    if (cur_len == 0) finish_pkt();
                end
            end else if (read_data_valid) begin
                idle_run = 0;
                if (!active || in_hdr || exp_data[cur].size() == 0) begin
                    chk("spurious_data", 32'd1, 32'd0);
                end else begin
                    chk("data", package_out, exp_data[cur][0]);
                    chk("data_rd", req_rd, package_ack ? oh(cur) : '0);
                    chk("data_grant", grant, oh(cur));
                    if (package_ack) begin
                        void'(exp_data[cur].pop_front());
                        cur_len--;
                        if (cur_len == 0) finish_pkt();
                    end
                end
            end else begin
                chk("idle_rd", req_rd, 32'd0);
                chk("idle_grant", grant, 32'd0);
                idle_run++;
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            env_data[i].delete();
            env_len[i].delete();
            exp_data[i].delete();
            exp_len[i].delete();
            env_popped[i] = 0;
        end
        gr_last   = '0;
        rd_s      = '0;
        model_ptr = 0;
        in_hdr    = 1'b0;
        active    = 1'b0;
        had_pkt   = 1'b0;
        idle_run  = 0;
        pkts_done = 0;
        drive_req();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_hdr(output int at);
        at = -1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            #1;
            if (package_out_start && read_data_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("hdr_timeout", 32'd0, 32'd1);
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N; i++) n += exp_len[i].size();
        return n;
    endfunction

    initial begin
        int t0, t1, npk, len, expect_pkts;
        rst         = 1'b0;
        package_ack = 1'b1;
        clear_all();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", grant, 32'd0);
        chk("rst_rd", req_rd, 32'd0);
        chk("rst_out", package_out, 32'd0);
        chk("rst_valid", read_data_valid, 32'd0);
        chk("rst_start", package_out_start, 32'd0);
        rst = 1'b1;

        // Single packet on port 2, then ptr must sit at 3.
        @(negedge clk);
        push(2, 3, 8'hA1);
        wait_hdr(t0);
        chk("sp_hdr", package_out, 32'h03);
        chk("sp_start", package_out_start, 32'd1);
        chk("sp_grant", grant, 32'h4);
        chk("sp_hdr_rd", req_rd, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("sp_data", package_out, 8'hA1 + 8'(3 * k));
            chk("sp_data_start", package_out_start, 32'd0);
            chk("sp_rd", req_rd, 32'h4);
        end
        @(negedge clk);
        #1;
        chk("sp_gap_valid", read_data_valid, 32'd0);
        chk("sp_gap_grant", grant, 32'd0);
        chk("sp_gap_out", package_out, 32'd0);
        push(1, 1, 8'h11);
        push(3, 1, 8'h33);
        wait_hdr(t0);
        chk("sp_ptr3", grant, 32'h8);
        wait_hdr(t0);
        chk("sp_wrap", grant, 32'h2);

        // Round-robin with every port requesting length-1 packets.
        do_reset();
        push(0, 1, 8'h01);
        push(1, 1, 8'h02);
        push(2, 1, 8'h03);
        push(3, 1, 8'h04);
        push(0, 1, 8'h05);
        t0 = -1;
        for (int k = 0; k < 5; k++) begin
            wait_hdr(t1);
            chk("rr_order", grant, oh(k % N));
            if (t0 >= 0) chk("rr_spacing", t1 - t0, 32'd4);
            t0 = t1;
        end

        // Backpressure on the first payload byte.
        do_reset();
        push(0, 2, 8'hB1);
        wait_hdr(t0);
        @(negedge clk);
        package_ack = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk("bp_hold", package_out, 32'hB1);
            chk("bp_valid", read_data_valid, 32'd1);
            chk("bp_rd", req_rd, 32'd0);
        end
        @(negedge clk);
        package_ack = 1'b1;
        #1;
        chk("bp_resume", package_out, 32'hB1);
        chk("bp_resume_rd", req_rd, 32'h1);
        @(negedge clk);
        #1;
        chk("bp_byte2", package_out, 32'hB4);
        @(negedge clk);
        #1;
        chk("bp_end", read_data_valid, 32'd0);

        // Zero-length packet then a follow-on packet.
        do_reset();
        push(1, 0, 8'h00);
        push(2, 1, 8'h55);
        wait_hdr(t0);
        chk("zl_hdr", package_out, 32'h00);
        chk("zl_start", package_out_start, 32'd1);
        chk("zl_grant", grant, 32'h2);
        chk("zl_rd0", req_rd, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("zl_rd", req_rd, 32'd0);
            chk("zl_idle", read_data_valid, 32'd0);
        end
        wait_hdr(t1);
        chk("zl_spacing", t1 - t0, 32'd3);
        chk("zl_next", grant, 32'h4);

        // Reset in the middle of a length-5 packet.
        do_reset();
        push(2, 1, 8'h20);
        wait_hdr(t0);
        repeat (3) @(negedge clk);
        push(3, 5, 8'h50);
        wait_hdr(t0);
        chk("rm_grant", grant, 32'h8);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rm_in_data", package_out, 32'h53);
        rst = 1'b0;
        #1;
        chk("rm_grant0", grant, 32'd0);
        chk("rm_valid0", read_data_valid, 32'd0);
        chk("rm_start0", package_out_start, 32'd0);
        chk("rm_out0", package_out, 32'd0);
        chk("rm_rd0", req_rd, 32'd0);
        clear_all();
        push(1, 1, 8'h61);
        push(3, 1, 8'h63);
        @(negedge clk);
        rst = 1'b1;
        wait_hdr(t0);
        chk("rm_after", grant, 32'h2);

`ifdef PKT_OUT_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) push(1, 1, 8'(k));
        for (int k = 0; k < 3; k++) wait_hdr(t0);
        repeat (4) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("stats", pkt_count[16*i +: 16], (i == 1) ? 32'd3 : 32'd0);
        end
`endif

        // Randomized traffic with random backpressure.
        do_reset();
        expect_pkts = 0;
        for (int i = 0; i < N; i++) begin
            npk = $urandom_range(0, 4);
            if (i == 0 && npk == 0) npk = 1;
            for (int p = 0; p < npk; p++) begin
                len = ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 12);
                push(i, len, 8'($urandom));
                expect_pkts++;
            end
        end
        mon_en = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk);
            #1;
            package_ack = ($urandom_range(0, 9) < 7);
            if (pending() == 0 && !active && idle_run >= 3) break;
        end
        mon_en = 1'b0;
        chk("rand_drained", pending(), 32'd0);
        chk("rand_pkts", pkts_done, expect_pkts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
